regfl_rd: RTL and testbench
===========================

Name: regfl_rd

Overview:
Read-out engine for the 8 x 64-bit register file's flat 512-bit block output.
- On `start`, takes a snapshot of the whole block.
- Streams the snapshot one register per transfer over a valid/ready interface, in register-index order.
- Sits between the register file `q` bus and any serial consumer (checksum unit, memory writer, debug port).

Parameters:
W, 64, word width in bits
N, 8, number of words in the block
AW, 3, index width; must satisfy 2**AW >= N

Ports:
clk  input  1  clock; all state updates on rising edge
rst_b  input  1  asynchronous active-low reset
clr  input  1  synchronous abort; returns to IDLE; lower priority than rst_b
start  input  1  request a read-out; sampled only in IDLE
blk  input  N*W  flat block from the register file
busy  output  1  high from the cycle after an accepted start through the DONE cycle
o_valid  output  1  word available on o_data/o_idx
o_ready  input  1  consumer accepts word when o_valid && o_ready at a rising edge
o_data  output  W  current word
o_idx  output  AW  register index of the current word
done  output  1  one-cycle pulse after the last handshake

Behaviour:
- Reset (rst_b=0, asynchronous): state IDLE; outputs busy, o_valid, o_data, o_idx and done all 0; snapshot cleared to 0.
- Index mapping (fixed): register index k is at blk[(N-1-k)*W +: W]. Index 0 is the most significant word, matching the register file's write indexing.
- States: IDLE, SEND, DONE.
- IDLE:
  - start=1 at an edge: capture blk into the snapshot register, set cnt=0, go to SEND.
  - start=0: stay in IDLE.
- SEND:
  - o_valid=1, o_idx=cnt, o_data=snapshot word cnt.
  - On handshake with cnt==N-1: go to DONE.
  - On any other handshake: cnt++.
  - No handshake: o_data and o_idx held stable.
- DONE: done=1 and busy=1 for exactly one cycle, o_valid=0, then return to IDLE unconditionally.
- start outside IDLE is ignored; it is not queued. A new start is accepted in IDLE at the earliest in the cycle after DONE.
- Snapshot: changes on blk after the capture edge never affect the stream in progress.
- Timing:
  - Latency: start edge T gives o_valid=1 in the cycle after T.
  - With o_ready tied to 1, the N words occupy cycles T+1..T+N, done pulses at T+N+1, and busy drops at T+N+2.
- Outputs outside SEND: o_data=0 and o_idx=0.
- clr=1 at an edge in any state: go to IDLE and drop o_valid, busy and done. The snapshot is kept. No done pulse is generated.
- start and clr asserted together in IDLE: clr wins and the start is not accepted.
- Reset asserted mid-transfer: immediate IDLE with all outputs 0. The transfer is lost and no done pulse is generated.

Optional Feature:
Macro REGFL_RD_DESC_EN.
- Defined: stream in descending order. cnt starts at N-1 and decrements; the last word is index 0. o_idx still reports the true register index, and done follows the index-0 handshake.
- Undefined: ascending order 0..N-1 as above.
- Port list and timing are identical in both builds.

Test Plan:
1. Reset check: hold rst_b=0 for 25 ns -> busy=0, o_valid=0, o_data=0, o_idx=0 and done=0, including mid-cycle.
2. Basic read-out: blk word k = 64'h1111_0000_0000_0000*(k+1) (index 0 in bits 511:448), start for 1 cycle, o_ready=1 -> eight transfers, o_idx 0..7, o_data matching each word, done at T+9, busy low at T+10.
3. Backpressure and snapshot: o_ready toggles 1,0,0,1,...; blk changed to all-ones after start -> o_data/o_idx stable while stalled, all words are the pre-change values, no word dropped or duplicated.
4. Abort and reset: clr=1 while o_idx=3 -> IDLE next cycle with no done pulse; restart, then pulse rst_b=0 while o_idx=5 -> immediate all-zero outputs; next start streams from index 0.
5. Ignored start: start held high for the entire transfer -> exactly one read-out, then a new one begins one cycle after done (start seen in IDLE).
6. Descending build (REGFL_RD_DESC_EN defined), same blk as test 2 -> o_idx 7..0 with matching o_data, done after the index-0 handshake.

Source files
------------

// File: rtl/regfl_rd.sv
// regfl_rd: read-out engine for the register file's flat N x W block.
// On start it snapshots the whole block and streams it one word per
// valid/ready handshake, then pulses done for one cycle.
// Build option: define REGFL_RD_DESC_EN to stream indices N-1 down to 0
// instead of 0 up to N-1. Ports and timing are the same in both builds.
module regfl_rd #(
    parameter int W  = 64,
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic           clk,
    input  logic           rst_b,
    input  logic           clr,
    input  logic           start,
    input  logic [N*W-1:0] blk,
    output logic           busy,
    output logic           o_valid,
    input  logic           o_ready,
    output logic [W-1:0]   o_data,
    output logic [AW-1:0]  o_idx,
    output logic           done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

`ifdef REGFL_RD_DESC_EN
    localparam logic [AW-1:0] CNT_FIRST = AW'(N - 1);
    localparam logic [AW-1:0] CNT_LAST  = '0;
`else
    localparam logic [AW-1:0] CNT_FIRST = '0;
    localparam logic [AW-1:0] CNT_LAST  = AW'(N - 1);
`endif

    state_t         state_q, state_d;
    logic [AW-1:0]  cnt_q, cnt_d;
    logic [N*W-1:0] snap_q, snap_d;
    logic [W-1:0]   words [N];
    logic           hs;
    logic           accept;

    // A start only counts in IDLE and loses against a simultaneous clr.
    assign accept = (state_q == IDLE) && start && !clr;
    assign hs     = (state_q == SEND) && o_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clr overrides every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SEND;
            SEND:    if (hs && (cnt_q == CNT_LAST)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clr) begin
            state_d = IDLE;
        end
    end

    // Snapshot capture and word counter advance.
    always_comb begin
        snap_d = snap_q;
        cnt_d  = cnt_q;
        if (accept) begin
            snap_d = blk;
            cnt_d  = CNT_FIRST;
        end else if (hs && (cnt_q != CNT_LAST)) begin
`ifdef REGFL_RD_DESC_EN
            cnt_d = cnt_q - 1'b1;
`else
            cnt_d = cnt_q + 1'b1;
`endif
        end
    end

    // Snapshot and counter registers; the snapshot survives clr.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            snap_q <= '0;
            cnt_q  <= '0;
        end else begin
            snap_q <= snap_d;
            cnt_q  <= cnt_d;
        end
    end

    // Unpack the snapshot: index 0 lives in the most significant word.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            words[k] = snap_q[(N-1-k)*W +: W];
        end
    end

    // Outputs decoded from the state; data and index are zero outside SEND.
    always_comb begin
        busy    = 1'b0;
        o_valid = 1'b0;
        o_data  = '0;
        o_idx   = '0;
        done    = 1'b0;
        case (state_q)
            SEND: begin
                busy    = 1'b1;
                o_valid = 1'b1;
                o_idx   = cnt_q;
                o_data  = words[cnt_q];
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_regfl_rd.sv
// Bench for regfl_rd: reset, table-driven basic read-out, backpressure with
// snapshot, abort/reset, held start, and randomized streams against a
// transaction-level reference of the expected word sequence.
module tb_regfl_rd;

    localparam int W  = 64;
    localparam int N  = 8;
    localparam int AW = 3;

    logic           clk = 1'b0;
    logic           rst_b;
    logic           clr;
    logic           start;
    logic [N*W-1:0] blk;
    logic           busy;
    logic           o_valid;
    logic           o_ready;
    logic [W-1:0]   o_data;
    logic [AW-1:0]  o_idx;
    logic           done;

    int checks = 0;
    int errors = 0;

    regfl_rd #(.W(W), .N(N), .AW(AW)) dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .clr     (clr),
        .start   (start),
        .blk     (blk),
        .busy    (busy),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_idx   (o_idx),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stream position p -> register index expected on o_idx.
    function automatic int pos2idx(input int p);
`ifdef REGFL_RD_DESC_EN
        return N - 1 - p;
`else
        return p;
`endif
    endfunction

    function automatic logic [W-1:0] word_of(input logic [N*W-1:0] b, input int k);
        return b[(N-1-k)*W +: W];
    endfunction

    task automatic chk_idle_zero(input string tag);
        chk({tag, " busy"},    64'(busy),    64'd0);
        chk({tag, " o_valid"}, 64'(o_valid), 64'd0);
        chk({tag, " o_data"},  64'(o_data),  64'd0);
        chk({tag, " o_idx"},   64'(o_idx),   64'd0);
        chk({tag, " done"},    64'(done),    64'd0);
    endtask

    // Start a read-out of b and follow it to done. mode: 0 ready always,
    // 1 ready pattern 1,0,0 repeating, 2 random ready. chg overwrites blk
    // with all-ones right after the start edge.
    task automatic run_readout(input logic [N*W-1:0] b, input int mode,
                               input bit chg, input string tag);
        logic [W-1:0]  exp_w [N];
        logic [W-1:0]  pd;
        logic [AW-1:0] pi;
        int pos;
        int cyc;
        bit seen_done;
        bit last_hs;
        bit stalled;
        bit rdy;
        pos = 0; cyc = 0; seen_done = 0; last_hs = 0; stalled = 0;
        pd = '0; pi = '0;
        for (int k = 0; k < N; k++) exp_w[k] = word_of(b, k);
        blk = b; start = 1'b1; o_ready = 1'b0;
        step();
        start = 1'b0;
        if (chg) blk = '1;
        chk({tag, " first-cycle valid"}, 64'(o_valid), 64'd1);
        while (cyc < 200 && !seen_done) begin
            if (done === 1'b1) begin
                seen_done = 1;
            end else begin
                chk({tag, " busy in stream"}, 64'(busy), 64'd1);
                if (pos < N) begin
                    chk({tag, " valid in stream"}, 64'(o_valid), 64'd1);
                    chk({tag, " o_idx"}, 64'(o_idx), 64'(pos2idx(pos)));
                    chk({tag, " o_data"}, o_data, exp_w[pos2idx(pos)]);
                    if (stalled) begin
                        chk({tag, " stall data stable"}, o_data, pd);
                        chk({tag, " stall idx stable"}, 64'(o_idx), 64'(pi));
                    end
                end else begin
                    chk({tag, " extra word"}, 64'(o_valid), 64'd0);
                end
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = ((cyc % 3) == 0);
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                o_ready = rdy;
                pd = o_data;
                pi = o_idx;
                last_hs = rdy && (o_valid === 1'b1);
                stalled = !rdy;
                if (last_hs) pos++;
                step();
                cyc++;
            end
        end
        o_ready = 1'b0;
        chk({tag, " done within budget"}, 64'(seen_done), 64'd1);
        if (seen_done) begin
            chk({tag, " word count"}, 64'(pos), 64'(N));
            chk({tag, " done follows last handshake"}, 64'(last_hs), 64'd1);
            chk({tag, " valid low at done"}, 64'(o_valid), 64'd0);
            chk({tag, " busy at done"}, 64'(busy), 64'd1);
            if (mode == 0) chk({tag, " done cycle"}, 64'(cyc), 64'(N));
            step();
            chk({tag, " busy after done"}, 64'(busy), 64'd0);
            chk({tag, " single done pulse"}, 64'(done), 64'd0);
        end
    endtask

    typedef struct {
        logic rdy;
        logic ev;
        int   pos;
        logic eb;
        logic ed;
    } vec_t;

    vec_t           tv [10];
    logic [N*W-1:0] basic;
    logic [N*W-1:0] rb;

    initial begin
        int n;
        int nvalid;
        int exp_idx;

        tv[0] = '{1'b1, 1'b1, 0, 1'b1, 1'b0};
        tv[1] = '{1'b1, 1'b1, 1, 1'b1, 1'b0};
        tv[2] = '{1'b1, 1'b1, 2, 1'b1, 1'b0};
        tv[3] = '{1'b1, 1'b1, 3, 1'b1, 1'b0};
        tv[4] = '{1'b1, 1'b1, 4, 1'b1, 1'b0};
        tv[5] = '{1'b1, 1'b1, 5, 1'b1, 1'b0};
        tv[6] = '{1'b1, 1'b1, 6, 1'b1, 1'b0};
        tv[7] = '{1'b1, 1'b1, 7, 1'b1, 1'b0};
        tv[8] = '{1'b1, 1'b0, 0, 1'b1, 1'b1};
        tv[9] = '{1'b1, 1'b0, 0, 1'b0, 1'b0};

        for (int k = 0; k < N; k++) begin
            basic[(N-1-k)*W +: W] = 64'h1111_0000_0000_0000 * (k + 1);
        end

        // Reset held for more than 25 ns, checked at several points.
        rst_b = 1'b0; clr = 1'b0; start = 1'b0; o_ready = 1'b0; blk = basic;
        #3  chk_idle_zero("reset t3");
        #9  chk_idle_zero("reset t12");
        #8  chk_idle_zero("reset t20");
        #7  rst_b = 1'b1;
        step();
        chk_idle_zero("after reset");

        // Basic read-out from the vector table.
        blk = basic; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            o_ready = tv[i].rdy;
            exp_idx = tv[i].ev ? pos2idx(tv[i].pos) : 0;
            chk($sformatf("basic[%0d] o_valid", i), 64'(o_valid), 64'(tv[i].ev));
            chk($sformatf("basic[%0d] busy", i), 64'(busy), 64'(tv[i].eb));
            chk($sformatf("basic[%0d] done", i), 64'(done), 64'(tv[i].ed));
            chk($sformatf("basic[%0d] o_idx", i), 64'(o_idx), 64'(exp_idx));
            chk($sformatf("basic[%0d] o_data", i), o_data,
                tv[i].ev ? word_of(basic, exp_idx) : 64'd0);
            step();
        end
        o_ready = 1'b0;

        // Backpressure with blk overwritten after the start edge.
        run_readout(basic, 1, 1'b1, "bp");

        // Simultaneous start and clr in IDLE: start is dropped.
        blk = basic; start = 1'b1; clr = 1'b1;
        step();
        start = 1'b0; clr = 1'b0;
        chk("start+clr busy", 64'(busy), 64'd0);
        chk("start+clr valid", 64'(o_valid), 64'd0);
        step();
        chk("start+clr later valid", 64'(o_valid), 64'd0);

        // Abort with clr while index 3 is on the bus.
        blk = basic; start = 1'b1; o_ready = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!(o_valid === 1'b1 && o_idx === 3'd3) && n < 20) begin step(); n++; end
        chk("abort reached idx3", 64'(n < 20), 64'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk_idle_zero("after clr");
        step();
        chk("no done after clr", 64'(done), 64'd0);
        chk("idle after clr", 64'(busy), 64'd0);

        // Restart, then asynchronous reset while index 5 is on the bus.
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!(o_valid === 1'b1 && o_idx === 3'd5) && n < 20) begin step(); n++; end
        chk("reset reached idx5", 64'(n < 20), 64'd1);
        #2 rst_b = 1'b0;
        #1 chk_idle_zero("async reset");
        #10 chk_idle_zero("reset held");
        rst_b = 1'b1;
        o_ready = 1'b0;
        step();
        chk_idle_zero("after mid reset");
        run_readout(basic, 0, 1'b0, "restart");

        // Start held high throughout: one read-out, next one right after.
        blk = basic; start = 1'b1; o_ready = 1'b1;
        step();
        n = 0; nvalid = 0;
        while (done !== 1'b1 && n < 40) begin
            if (o_valid === 1'b1) nvalid++;
            step();
            n++;
        end
        chk("held start done seen", 64'(n < 40), 64'd1);
        chk("held start one read-out", 64'(nvalid), 64'(N));
        step();
        chk("held start idle busy", 64'(busy), 64'd0);
        chk("held start idle valid", 64'(o_valid), 64'd0);
        step();
        chk("held start restart valid", 64'(o_valid), 64'd1);
        chk("held start restart idx", 64'(o_idx), 64'(pos2idx(0)));
        start = 1'b0; clr = 1'b1; o_ready = 1'b0;
        step();
        clr = 1'b0;
        chk("held start cleared", 64'(busy), 64'd0);

        // Randomized blocks and ready patterns.
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 2 * N; k++) rb[k*32 +: 32] = $urandom;
            run_readout(rb, 2, r[0], $sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
